enigma_rotor_path: RTL and testbench

//   Complete Enigma I/M3 signal path for one keypress: plugboard, right/middle/left rotors

---
 rtl/enigma_rotor_path_if.sv | 37 +++
 rtl/enigma_rotor_path.sv | 147 ++++++++++++++
 tb/tb_enigma_rotor_path.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/enigma_rotor_path_if.sv
// Keypress request / ciphertext response bundle for the Enigma signal path.
// The master drives a keypress and its machine settings; the slave returns the registered result.
interface enigma_rotor_path_if;
    logic         in_valid;
    logic [4:0]   pt_index;
    logic [2:0]   rotor_sel_l;
    logic [2:0]   rotor_sel_m;
    logic [2:0]   rotor_sel_r;
    logic [4:0]   ring_l;
    logic [4:0]   ring_m;
    logic [4:0]   ring_r;
    logic [4:0]   pos_l;
    logic [4:0]   pos_m;
    logic [4:0]   pos_r;
    logic [129:0] plug_map;
    logic         out_valid;
    logic [4:0]   mid_letter;
    logic [4:0]   ct_index;

    modport master (
        output in_valid, pt_index,
        output rotor_sel_l, rotor_sel_m, rotor_sel_r,
        output ring_l, ring_m, ring_r,
        output pos_l, pos_m, pos_r,
        output plug_map,
        input  out_valid, mid_letter, ct_index
    );

    modport slave (
        input  in_valid, pt_index,
        input  rotor_sel_l, rotor_sel_m, rotor_sel_r,
        input  ring_l, ring_m, ring_r,
        input  pos_l, pos_m, pos_r,
        input  plug_map,
        output out_valid, mid_letter, ct_index
    );
endinterface

// File: rtl/enigma_rotor_path.sv
// Enigma I/M3 keypress path: plugboard, three rotors forward, reflector, rotors backward,
// plugboard again. Rotor positions come from outside; one output register gives 1-cycle latency.
module enigma_rotor_path #(
    parameter int unsigned REFLECTOR = 0
) (
    input logic                clk,
    input logic                rst,
    enigma_rotor_path_if.slave bus
);
    typedef logic [4:0]      letter_t;
    typedef logic [8*26-1:0] table_t;

    localparam letter_t Invalid = 5'd31;

    // Wiring tables stored as ASCII; contact A is the most significant byte.
    localparam table_t RotorWiring [8] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK",
        "JPGVOUMFYQBENHZRDKASXLICTW",
        "NZJHGRCXMYSWBOUFAQVLPDKITE",
        "FKQHTLXOCBJSPDZRAMEWNIUYGV"
    };

    localparam table_t ReflectorWiring = (REFLECTOR == 0) ? "YRUHQSLDPXNGOKMIEBFZCWVJAT"
                                                          : "FVPJIAOYEDRZXWGCTKUQSBNMHL";

    // Callers guarantee idx < 26.
    function automatic letter_t table_lookup(input table_t tbl, input letter_t idx);
        int unsigned bit_pos;
        logic [7:0]  ch;
        bit_pos = (25 - int'(idx)) * 8;
        ch      = tbl[bit_pos +: 8];
        return letter_t'(ch - 8'd65);
    endfunction

    function automatic letter_t table_inverse(input table_t tbl, input letter_t val);
        letter_t res;
        res = '0;
        for (int i = 0; i < 26; i++) begin
            if (table_lookup(tbl, letter_t'(i)) == val) begin
                res = letter_t'(i);
            end
        end
        return res;
    endfunction

    function automatic letter_t mod_add(input letter_t a, input letter_t b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 6'd26) begin
            sum = sum - 6'd26;
        end
        return sum[4:0];
    endfunction

    // The 6-bit difference wraps when a < b; adding 26 lands back in 0..25.
    function automatic letter_t mod_sub(input letter_t a, input letter_t b);
        logic [5:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            diff = diff + 6'd26;
        end
        return diff[4:0];
    endfunction

    function automatic letter_t reduce(input letter_t x);
        return (x >= 5'd26) ? (x - 5'd26) : x;
    endfunction

    function automatic letter_t plug_entry(input logic [129:0] map, input letter_t idx);
        letter_t res;
        res = Invalid;
        for (int i = 0; i < 26; i++) begin
            if (idx == letter_t'(i)) begin
                res = map[i*5 +: 5];
            end
        end
        return res;
    endfunction

    function automatic letter_t rotor_fwd(input logic [2:0] sel, input letter_t off,
                                          input letter_t x);
        return mod_sub(table_lookup(RotorWiring[sel], mod_add(x, off)), off);
    endfunction

    function automatic letter_t rotor_bwd(input logic [2:0] sel, input letter_t off,
                                          input letter_t x);
        return mod_sub(table_inverse(RotorWiring[sel], mod_add(x, off)), off);
    endfunction

    letter_t off_l, off_m, off_r;
    letter_t plug_in, path_in;
    letter_t fwd_r, fwd_m, fwd_l;
    letter_t refl;
    letter_t bwd_l, bwd_m, bwd_r;
    letter_t plug_out;
    logic    invalid;
    letter_t mid_d, ct_d;

    always_comb begin
        off_l = mod_sub(reduce(bus.pos_l), reduce(bus.ring_l));
        off_m = mod_sub(reduce(bus.pos_m), reduce(bus.ring_m));
        off_r = mod_sub(reduce(bus.pos_r), reduce(bus.ring_r));

        plug_in = plug_entry(bus.plug_map, bus.pt_index);
        // Keep the rotor tables indexed in range even when the result is discarded.
        path_in = (plug_in >= 5'd26) ? '0 : plug_in;

        fwd_r = rotor_fwd(bus.rotor_sel_r, off_r, path_in);
        fwd_m = rotor_fwd(bus.rotor_sel_m, off_m, fwd_r);
        fwd_l = rotor_fwd(bus.rotor_sel_l, off_l, fwd_m);
        refl  = table_lookup(ReflectorWiring, fwd_l);
        bwd_l = rotor_bwd(bus.rotor_sel_l, off_l, refl);
        bwd_m = rotor_bwd(bus.rotor_sel_m, off_m, bwd_l);
        bwd_r = rotor_bwd(bus.rotor_sel_r, off_r, bwd_m);

        plug_out = plug_entry(bus.plug_map, bwd_r);

        invalid = (bus.pt_index >= 5'd26) || (plug_in >= 5'd26) || (plug_out >= 5'd26);
        mid_d   = invalid ? Invalid : refl;
        ct_d    = invalid ? Invalid : plug_out;
    end

    logic    valid_q;
    letter_t mid_q, ct_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            mid_q   <= '0;
            ct_q    <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                mid_q <= mid_d;
                ct_q  <= ct_d;
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.mid_letter = mid_q;
    assign bus.ct_index   = ct_q;
endmodule

// File: tb/tb_enigma_rotor_path.sv
// Bench for enigma_rotor_path: directed known-answer cases plus randomized settings checked
// against a table-driven Enigma model.
module tb_enigma_rotor_path;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enigma_rotor_path_if bus ();

    enigma_rotor_path #(.REFLECTOR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    string rotor_w [8] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK", "JPGVOUMFYQBENHZRDKASXLICTW",
        "NZJHGRCXMYSWBOUFAQVLPDKITE", "FKQHTLXOCBJSPDZRAMEWNIUYGV"
    };
    string refl_w = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    int rotor_inv [8][26];
    // Index 0 = left, 1 = middle, 2 = right.
    int sel [3];
    int ring [3];
    int pos [3];
    int plug [26];
    int n_pass = 0;
    int n_total = 0;
    int exp_mid;
    int exp_ct;
    int ct;
    int back;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int wire_at(input int k, input int i);
        return int'(rotor_w[k].getc(i)) - 65;
    endfunction

    function automatic int fwd(input int k, input int s, input int x);
        return (wire_at(k, (x + s) % 26) - s + 26) % 26;
    endfunction

    function automatic int bwd(input int k, input int s, input int x);
        return (rotor_inv[k][(x + s) % 26] - s + 26) % 26;
    endfunction

    task automatic model(input int pt, output int mid, output int c);
        int x;
        int s [3];
        mid = 31;
        c   = 31;
        if (pt >= 26) return;
        for (int k = 0; k < 3; k++) s[k] = ((pos[k] % 26) - (ring[k] % 26) + 26) % 26;
        x = plug[pt];
        if (x >= 26) return;
        x = fwd(sel[2], s[2], x);
        x = fwd(sel[1], s[1], x);
        x = fwd(sel[0], s[0], x);
        mid = int'(refl_w.getc(x)) - 65;
        x = bwd(sel[0], s[0], mid);
        x = bwd(sel[1], s[1], x);
        x = bwd(sel[2], s[2], x);
        c = plug[x];
        if (c >= 26) begin
            mid = 31;
            c   = 31;
        end
    endtask

    task automatic set_cfg(input int l, input int m, input int r,
                           input int pl, input int pm, input int pr);
        sel[0] = l; sel[1] = m; sel[2] = r;
        for (int k = 0; k < 3; k++) ring[k] = 0;
        pos[0] = pl; pos[1] = pm; pos[2] = pr;
    endtask

    task automatic plug_identity();
        for (int i = 0; i < 26; i++) plug[i] = i;
    endtask

    // Drive one cycle, then check out_valid and data (new result or held value).
    task automatic step(input string tag, input bit v, input int pt, output int got_ct);
        int m, c;
        bus.in_valid    = v;
        bus.pt_index    = 5'(pt);
        bus.rotor_sel_l = 3'(sel[0]);
        bus.rotor_sel_m = 3'(sel[1]);
        bus.rotor_sel_r = 3'(sel[2]);
        bus.ring_l      = 5'(ring[0]);
        bus.ring_m      = 5'(ring[1]);
        bus.ring_r      = 5'(ring[2]);
        bus.pos_l       = 5'(pos[0]);
        bus.pos_m       = 5'(pos[1]);
        bus.pos_r       = 5'(pos[2]);
        for (int i = 0; i < 26; i++) bus.plug_map[i*5 +: 5] = 5'(plug[i]);
        if (v) begin
            model(pt, m, c);
            exp_mid = m;
            exp_ct  = c;
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, int'(bus.out_valid), int'(v));
        check_eq({tag, "_mid"}, int'(bus.mid_letter), exp_mid);
        check_eq({tag, "_ct"}, int'(bus.ct_index), exp_ct);
        got_ct = int'(bus.ct_index);
    endtask

    initial begin
        int pos_exp [5] = '{1, 3, 25, 6, 14};
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 26; i++) rotor_inv[k][wire_at(k, i)] = i;

        rst = 1'b1;
        set_cfg(0, 1, 2, 0, 0, 1);
        plug_identity();
        bus.in_valid = 1'b1;
        bus.pt_index = '0;
        bus.rotor_sel_l = '0; bus.rotor_sel_m = '0; bus.rotor_sel_r = '0;
        bus.ring_l = '0; bus.ring_m = '0; bus.ring_r = '0;
        bus.pos_l = '0; bus.pos_m = '0; bus.pos_r = '0;
        bus.plug_map = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_valid", int'(bus.out_valid), 0);
        check_eq("reset_mid", int'(bus.mid_letter), 0);
        check_eq("reset_ct", int'(bus.ct_index), 0);
        rst = 1'b0;
        exp_mid = 0;
        exp_ct  = 0;

        step("aab_a", 1'b1, 0, ct);
        check_eq("aab_a_known_ct", ct, 1);
        check_eq("aab_a_known_mid", int'(bus.mid_letter), 18);
        step("aab_b", 1'b1, 1, ct);
        check_eq("aab_b_known_ct", ct, 0);

        for (int p = 0; p < 26; p++) begin
            step("sweep", 1'b1, p, ct);
            check_eq("sweep_ct_ne_pt", int'(ct == p), 0);
            step("sweep_back", 1'b1, ct, back);
            check_eq("sweep_reciprocal", back, p);
        end

        for (int i = 0; i < 5; i++) begin
            pos[2] = i + 1;
            step("pos_seq", 1'b1, 0, ct);
            check_eq("pos_seq_known", ct, pos_exp[i]);
        end

        pos[2] = 1;
        plug[0] = 25;
        plug[25] = 0;
        step("plug_z", 1'b1, 25, ct);
        check_eq("plug_z_known", ct, 1);
        step("plug_a", 1'b1, 0, ct);
        plug_identity();

        step("bad_pt", 1'b1, 27, ct);
        check_eq("bad_pt_known", ct, 31);
        step("idle", 1'b0, 3, ct);
        step("idle2", 1'b0, 4, ct);

        for (int n = 0; n < 400; n++) begin
            int a, b, pt;
            for (int k = 0; k < 3; k++) begin
                sel[k]  = $urandom_range(7);
                ring[k] = $urandom_range(31);
                pos[k]  = $urandom_range(31);
            end
            plug_identity();
            for (int t = 0; t < 10; t++) begin
                a = $urandom_range(25);
                b = $urandom_range(25);
                if (a != b && plug[a] == a && plug[b] == b) begin
                    plug[a] = b;
                    plug[b] = a;
                end
            end
            if ($urandom_range(9) == 0) plug[$urandom_range(25)] = $urandom_range(31, 26);
            pt = ($urandom_range(15) == 0) ? $urandom_range(31, 26) : $urandom_range(25);
            step("rand", ($urandom_range(4) != 0), pt, ct);
        end

        set_cfg(0, 1, 2, 0, 0, 1);
        plug_identity();
        step("pre_rst", 1'b1, 5, ct);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_valid", int'(bus.out_valid), 0);
        check_eq("rst_mid_ct", int'(bus.ct_index), 0);
        check_eq("rst_mid_mid", int'(bus.mid_letter), 0);
        rst = 1'b0;
        exp_mid = 0;
        exp_ct  = 0;
        step("post_rst", 1'b1, 0, ct);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
